mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have MEMR_in, input, 1, load request from EX/MEM register.
REQ-004 SHALL have MEMW_in, input, 1, store request from EX/MEM register. MEMR_in and MEMW_in both high is treated as a load.
REQ-005 SHALL have MEM_Ctrl_in, input, 4, access type:
- [1:0] size: 00 byte, 01 half, 10 word, 11 reserved, treated as word.
- [2] unsigned load.
- [3] ignored.
REQ-006 SHALL have ALU_in, input, 32, byte address.
REQ-007 SHALL have rs2_in, input, 32, store data.
REQ-008 SHALL have dmem_req, output, 1, bus request.
REQ-009 SHALL have dmem_we, output, 1, write enable.
REQ-010 SHALL have dmem_addr, output, 32, word address, with [1:0] = 00.
REQ-011 SHALL have dmem_be, output, 4, byte enables.
REQ-012 SHALL have dmem_wdata, output, 32, lane-replicated store data.
REQ-013 SHALL have dmem_gnt, input, 1, request accepted.
REQ-014 SHALL have dmem_rvalid, input, 1, read data valid.
REQ-015 SHALL have dmem_rdata, input, 32, read data.
REQ-016 SHALL have load_data, output, 32, formatted load result.
REQ-017 SHALL have stall, output, 1, freezes the IF/ID/EX/MEM stages.
REQ-018 SHALL have misalign, output, 1, one-cycle exception pulse.

Function
REQ-019 SHALL implement a state machine with states IDLE, REQ, RESP and DONE.
REQ-020 SHALL define an access as MEMR_in or MEMW_in high in IDLE.
- A misaligned access is half with addr[0]=1, or word with addr[1:0]≠00.
REQ-021 On an aligned access in IDLE, SHALL:
- assert stall combinationally in the same cycle;
- latch the address, write data, be, we and ctrl;
- move to REQ.
REQ-022 On a misaligned access in IDLE, SHALL:
- pulse misalign for 1 cycle;
- issue no bus request;
- keep stall low and stay in IDLE.
REQ-023 In REQ, SHALL hold dmem_req=1 with stable bus outputs until dmem_gnt=1.
- Store: go to DONE.
- Load: go to RESP.
REQ-024 In RESP, SHALL hold stall; on dmem_rvalid=1, SHALL register the formatted dmem_rdata into load_data and go to DONE.
- dmem_rvalid in the same cycle as dmem_gnt SHALL be ignored; the response is taken in RESP only.
REQ-025 In DONE, SHALL drive stall=0 for exactly 1 cycle so the pipeline advances, then go to IDLE. DONE SHALL NOT start a new access.
REQ-026 SHALL assert stall in IDLE when an aligned access is present, and in REQ and RESP; otherwise stall SHALL be 0.
REQ-027 Byte enables SHALL be:
- SB: 0001 << addr[1:0].
- SH: 0011 << {addr[1],1'b0}.
- SW: 1111.
REQ-028 Write data SHALL be:
- SB: rs2[7:0] replicated ×4.
- SH: rs2[15:0] replicated ×2.
- SW: rs2 unchanged.
REQ-029 Load formatting SHALL shift rdata right by 8·addr[1:0], then sign-extend from bit 7 or 15, or zero-extend when ctrl[2]=1; word loads SHALL pass unchanged.
REQ-030 load_data SHALL hold its value until the next completed load.
REQ-031 Load latency SHALL be 3 + (gnt wait) + (rvalid wait) cycles from access to DONE; with zero-wait gnt and rvalid, stall SHALL be high for exactly 3 cycles.
REQ-032 Store latency with zero-wait gnt SHALL be stall high for exactly 2 cycles.

Reset
REQ-033 On rst, SHALL go to IDLE and set dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, misalign and stall to 0.
REQ-034 An rst in REQ or RESP SHALL abandon the transaction: dmem_req=0 on the next cycle, and any late rvalid SHALL be ignored in IDLE.

Structure
REQ-035 A shared package SHALL hold:
- the state enum;
- MEM_Ctrl size constants SZ_B, SZ_H, SZ_W;
- the unsigned-bit index.
REQ-036 SHALL contain one combinational sub-module, load_formatter (rdata, offset, ctrl → load_data).

Verification
REQ-037 LW at 0x100 with gnt at 0 wait and rvalid the next cycle, rdata=0xDEADBEEF → be=1111, stall high 3 cycles, load_data=0xDEADBEEF.
REQ-038 LB at 0x103 with rdata=0x80112233 → load_data=0xFFFFFF80; the same access as LBU → 0x00000080.
REQ-039 SH at 0x202 with rs2=0x0000ABCD → dmem_addr=0x200, be=1100, wdata=0xABCDABCD, stall high 2 cycles.
REQ-040 LW at 0x101 → misalign pulses 1 cycle, dmem_req never asserted, stall=0.
REQ-041 SW with dmem_gnt held low 5 cycles → dmem_req and bus outputs stable 5 cycles, stall high 6 cycles, then DONE.
REQ-042 rst asserted in RESP, then rvalid 1 cycle later → IDLE, load_data=0, stall=0, rvalid ignored.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // MEM_Ctrl[1:0] access size; 2'b11 is reserved and behaves as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // MEM_Ctrl bit selecting zero-extension of sub-word loads.
  localparam int CTRL_UNSIGNED_BIT = 2;

  // Halfwords need an even address; words (and the reserved size) need a
  // word-aligned address; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    case (size)
      SZ_B:    result = 1'b0;
      SZ_H:    result = offset[0];
      default: result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_load_formatter.sv
// Combinational load formatter: selects the addressed byte/half of a read
// word and sign- or zero-extends it; words pass through untouched.
module load_formatter
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  ctrl,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  // Lane selection equals rdata >> (8*offset) truncated to the access size.
  always_comb begin
    byte_sel    = rdata[{offset, 3'b000} +: 8];
    half_sel    = offset[1] ? rdata[31:16] : rdata[15:0];
    is_unsigned = ctrl[CTRL_UNSIGNED_BIT];
    case (ctrl[1:0])
      SZ_B:    load_data = is_unsigned ? {24'h000000, byte_sel}
                                       : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = is_unsigned ? {16'h0000, half_sel}
                                       : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into a
// req/gnt + rvalid bus transaction, stalling the pipeline while it runs.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEMR_in,
  input  logic                   MEMW_in,
  input  logic [3:0]             MEM_Ctrl_in,
  input  logic [31:0]            ALU_in,
  input  logic [31:0]            rs2_in,
  mem_stage_lsu_if.master        dmem,
  output logic [31:0]            load_data,
  output logic                   stall,
  output logic                   misalign
);

  lsu_state_t  state_reg, state_next;

  logic        access;
  logic        misaligned_in;
  logic        start_access;
  logic [1:0]  size_in;
  logic [1:0]  offset_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  logic [29:0] word_addr_reg;
  logic [1:0]  offset_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic        we_reg;
  logic [2:0]  ctrl_reg;
  logic [31:0] load_data_reg;
  logic [31:0] fmt_data;

  // MEM_Ctrl[3] carries nothing for this unit.
  logic        unused_ctrl_bit;
  assign unused_ctrl_bit = MEM_Ctrl_in[3];

  assign size_in       = MEM_Ctrl_in[1:0];
  assign offset_in     = ALU_in[1:0];
  assign access        = MEMR_in | MEMW_in;
  assign misaligned_in = is_misaligned(size_in, offset_in);
  assign start_access  = (state_reg == IDLE) && access && !misaligned_in;

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    case (size_in)
      SZ_B: begin
        be_in    = 4'b0001 << offset_in;
        wdata_in = {4{rs2_in[7:0]}};
      end
      SZ_H: begin
        be_in    = 4'b0011 << {offset_in[1], 1'b0};
        wdata_in = {2{rs2_in[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = rs2_in;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a load wins when both request lines are high.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_access)     state_next = REQ;
      REQ:  if (dmem.dmem_gnt)    state_next = we_reg ? DONE : RESP;
      RESP: if (dmem.dmem_rvalid) state_next = DONE;
      DONE:                       state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Control outputs; forced low while reset is applied.
  always_comb begin
    stall         = 1'b0;
    misalign      = 1'b0;
    dmem.dmem_req = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          stall    = start_access;
          misalign = access && misaligned_in;
        end
        REQ: begin
          stall         = 1'b1;
          dmem.dmem_req = 1'b1;
        end
        RESP:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Capture the access on entry and the formatted read data on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_addr_reg <= '0;
      offset_reg    <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      ctrl_reg      <= '0;
      load_data_reg <= '0;
    end else begin
      if (start_access) begin
        word_addr_reg <= ALU_in[31:2];
        offset_reg    <= offset_in;
        be_reg        <= be_in;
        wdata_reg     <= wdata_in;
        we_reg        <= MEMW_in && !MEMR_in;
        ctrl_reg      <= MEM_Ctrl_in[2:0];
      end
      if ((state_reg == RESP) && dmem.dmem_rvalid) begin
        load_data_reg <= fmt_data;
      end
    end
  end

  load_formatter u_load_formatter (
    .rdata     (dmem.dmem_rdata),
    .offset    (offset_reg),
    .ctrl      (ctrl_reg),
    .load_data (fmt_data)
  );

  assign dmem.dmem_addr  = {word_addr_reg, 2'b00};
  assign dmem.dmem_be    = be_reg;
  assign dmem.dmem_wdata = wdata_reg;
  assign dmem.dmem_we    = dmem.dmem_req & we_reg;
  assign load_data       = load_data_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a load-result scoreboard queue.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        memr, memw;
  logic [3:0]  ctrl;
  logic [31:0] alu, rs2;
  logic [31:0] load_data;
  logic        stall, misalign;

  mem_stage_lsu_if bus ();

  mem_stage_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .MEMR_in     (memr),
    .MEMW_in     (memw),
    .MEM_Ctrl_in (ctrl),
    .ALU_in      (alu),
    .rs2_in      (rs2),
    .dmem        (bus),
    .load_data   (load_data),
    .stall       (stall),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one aligned access from the cycle after a rising edge until DONE,
  // acting as the memory: gnt after gnt_wait cycles of req, rvalid after
  // rv_wait cycles in RESP. A bogus rvalid accompanies gnt to prove it is
  // ignored.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [3:0] ctrl_v, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata_v,
                            input int gnt_wait, input int rv_wait,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                            input int exp_stall);
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    int   resp_cnt  = 0;
    int   cyc       = 0;
    bit   granted   = 0;
    bit   done      = 0;
    logic is_store;
    logic s;
    is_store = wr && !rd;
    memr = rd; memw = wr; ctrl = ctrl_v; alu = addr; rs2 = data;
    if (rd) exp_q.push_back(exp_load);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      s = stall;
      if (s) stall_cnt++;
      if (bus.dmem_req) begin
        req_cnt++;
        chk({tag, " addr"}, bus.dmem_addr, exp_addr);
        chk({tag, " be"}, {28'h0, bus.dmem_be}, {28'h0, exp_be});
        chk({tag, " we"}, {31'h0, bus.dmem_we}, {31'h0, is_store});
        if (is_store) chk({tag, " wdata"}, bus.dmem_wdata, exp_wdata);
        bus.dmem_gnt    = (req_cnt > gnt_wait);
        bus.dmem_rvalid = bus.dmem_gnt;
        bus.dmem_rdata  = ~rdata_v;
        if (bus.dmem_gnt) granted = 1;
      end else if (s && granted) begin
        bus.dmem_rvalid = (resp_cnt >= rv_wait);
        bus.dmem_rdata  = bus.dmem_rvalid ? rdata_v : 32'h0;
        resp_cnt++;
      end else if (!s && granted) begin
        done = 1;
        memr = 1'b0; memw = 1'b0;
        if (rd) begin
          last_load = exp_q.pop_front();
        end
        chk({tag, " load_data"}, load_data, last_load);
      end
      @(posedge clk); #1;
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    end
    memr = 1'b0; memw = 1'b0;
    chk({tag, " reached DONE"}, {31'h0, done}, 32'h1);
    chk({tag, " stall cycles"}, stall_cnt, exp_stall);
    chk({tag, " req cycles"}, req_cnt, gnt_wait + 1);
    $display("%s: addr=%h stall_cycles=%0d req_cycles=%0d load_data=%h", tag, addr, stall_cnt, req_cnt, load_data);
  endtask

  // A misaligned access must pulse misalign without a bus request or stall.
  task automatic run_misalign(input string tag, input logic [3:0] ctrl_v, input logic [31:0] addr);
    memr = 1'b1; memw = 1'b0; ctrl = ctrl_v; alu = addr;
    @(negedge clk);
    chk({tag, " misalign"}, {31'h0, misalign}, 32'h1);
    chk({tag, " stall"}, {31'h0, stall}, 32'h0);
    chk({tag, " req"}, {31'h0, bus.dmem_req}, 32'h0);
    @(posedge clk); #1;
    memr = 1'b0;
    @(negedge clk);
    chk({tag, " misalign after"}, {31'h0, misalign}, 32'h0);
    chk({tag, " req after"}, {31'h0, bus.dmem_req}, 32'h0);
    @(posedge clk); #1;
    $display("%s: addr=%h misaligned access trapped", tag, addr);
  endtask

  initial begin
    rst = 1'b1; memr = 1'b0; memw = 1'b0; ctrl = 4'h0; alu = 32'h0; rs2 = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset req", {31'h0, bus.dmem_req}, 32'h0);
    chk("reset be", {28'h0, bus.dmem_be}, 32'h0);
    chk("reset addr", bus.dmem_addr, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset: outputs cleared");

    run_access("LW 0x100", 1, 0, 4'b0010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
               32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3);
    run_access("LB 0x103", 1, 0, 4'b0000, 32'h103, 32'h0, 32'h80112233, 0, 0,
               32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 3);
    run_access("LBU 0x103", 1, 0, 4'b0100, 32'h103, 32'h0, 32'h80112233, 0, 0,
               32'h100, 4'b1000, 32'h0, 32'h00000080, 3);
    run_access("LH 0x102 waits", 1, 0, 4'b0001, 32'h102, 32'h0, 32'h80017FFF, 1, 2,
               32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 6);
    run_access("LHU 0x100", 1, 0, 4'b0101, 32'h100, 32'h0, 32'h12349ABC, 0, 1,
               32'h100, 4'b0011, 32'h0, 32'h00009ABC, 4);
    run_access("SH 0x202", 0, 1, 4'b0001, 32'h202, 32'h0000ABCD, 32'h0, 0, 0,
               32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 2);
    run_access("SB 0x301", 0, 1, 4'b0000, 32'h301, 32'h123456A5, 32'h0, 0, 0,
               32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0, 2);
    run_access("SW gnt wait", 0, 1, 4'b0010, 32'h400, 32'hCAFEF00D, 32'h0, 4, 0,
               32'h400, 4'b1111, 32'hCAFEF00D, 32'h0, 6);
    run_access("LW rsvd both", 1, 1, 4'b1111, 32'h404, 32'h11111111, 32'h55AA33CC, 0, 0,
               32'h404, 4'b1111, 32'h0, 32'h55AA33CC, 3);

    run_misalign("LW 0x101", 4'b0010, 32'h101);
    run_misalign("LH 0x203", 4'b0001, 32'h203);

    // Reset while waiting for read data, then a late rvalid in IDLE.
    memr = 1'b1; memw = 1'b0; ctrl = 4'b0010; alu = 32'h300;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst-resp req", {31'h0, bus.dmem_req}, 32'h1);
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    chk("rst-resp stall in RESP", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; memr = 1'b0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rst-resp stall", {31'h0, stall}, 32'h0);
    chk("rst-resp req after", {31'h0, bus.dmem_req}, 32'h0);
    chk("rst-resp load_data", load_data, 32'h0);
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst-resp late rvalid ignored", load_data, 32'h0);
    chk("rst-resp idle stall", {31'h0, stall}, 32'h0);
    $display("rst in RESP: load_data=%h stall=%0b", load_data, stall);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
